// File: rtl/iterative_divider_pkg.sv
// Shared ISA types for the iterative divider: data width, opcodes, flag word and divider FSM states.
package iterative_divider_pkg;

  localparam int DataWidth = 16;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_MUL,
    OP_DIV,
    OP_MOD
  } eOperation;

  typedef struct packed {
    logic Carry;
    logic Zero;
    logic Negative;
    logic Overflow;
    logic Parity;
  } sFlags;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } eDivState;

endpackage

// File: rtl/iterative_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and trial-subtract.
module divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder stays below the divisor (or below 2**WIDTH when the
  // divisor is zero), so the kept remainder always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_in, q_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_out   = {q_in[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed DIV/MOD unit, one quotient bit per clock, Start/Busy/Done handshake.
// Optional DIVIDER_ZERO_TRAP_EN: a zero divisor returns the dividend and raises Overflow.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = DataWidth
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  eOperation        Operation,
  input  logic [WIDTH-1:0] InDest,
  input  logic [WIDTH-1:0] InSrc,
  input  sFlags            InFlags,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] OutDest,
  output sFlags            OutFlags
);

  localparam int CntW = $clog2(WIDTH);

  eDivState         state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             is_mod_q, is_mod_d;
  logic             q_neg_q, q_neg_d;
  logic             rem_neg_q, rem_neg_d;
  sFlags            in_flags_q, in_flags_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] dest_q, dest_d;
  sFlags            out_flags_q, out_flags_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_signed, rem_signed, result;
  sFlags            result_flags;
  logic             accept;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .q_in    (quo_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_out   (step_quo)
  );

  assign accept = Start && (Operation == OP_DIV || Operation == OP_MOD);

  // Sign correction and flag generation, consumed in DIV_FIX.
  always_comb begin
    quo_signed   = q_neg_q   ? ('0 - quo_q) : quo_q;
    rem_signed   = rem_neg_q ? ('0 - rem_q) : rem_q;
    result       = is_mod_q ? rem_signed : quo_signed;
    result_flags = in_flags_q;
`ifdef DIVIDER_ZERO_TRAP_EN
    // With a zero divisor the signed remainder is exactly the dividend.
    if (divisor_q == '0) begin
      result                = rem_signed;
      result_flags.Overflow = 1'b1;
    end else begin
      result_flags.Overflow = 1'b0;
    end
`endif
    result_flags.Zero     = (result == '0);
    result_flags.Negative = result[WIDTH-1];
    result_flags.Parity   = ~^result;
  end

  // NOTE: every _d gets its hold value first so no path through the case leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    is_mod_d    = is_mod_q;
    q_neg_d     = q_neg_q;
    rem_neg_d   = rem_neg_q;
    in_flags_d  = in_flags_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    divisor_d   = divisor_q;
    dest_d      = dest_q;
    out_flags_d = out_flags_q;

    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (accept) begin
          state_d    = DIV_CALC;
          count_d    = CntW'(WIDTH - 1);
          is_mod_d   = (Operation == OP_MOD);
          q_neg_d    = InDest[WIDTH-1] ^ InSrc[WIDTH-1];
          rem_neg_d  = InDest[WIDTH-1];
          in_flags_d = InFlags;
          quo_d      = InDest[WIDTH-1] ? ('0 - InDest) : InDest;
          divisor_d  = InSrc[WIDTH-1]  ? ('0 - InSrc)  : InSrc;
          rem_d      = '0;
        end
      end
      DIV_CALC: begin
        quo_d   = step_quo;
        rem_d   = step_rem;
        count_d = count_q - 1'b1;
        if (count_q == '0) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        dest_d      = result;
        out_flags_d = result_flags;
        state_d     = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; all datapath registers are small and reset along with the FSM.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      is_mod_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      rem_neg_q   <= 1'b0;
      in_flags_q  <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      dest_q      <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      is_mod_q    <= is_mod_d;
      q_neg_q     <= q_neg_d;
      rem_neg_q   <= rem_neg_d;
      in_flags_q  <= in_flags_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      divisor_q   <= divisor_d;
      dest_q      <= dest_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign Busy     = (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign Done     = (state_q == DIV_DONE);
  assign OutDest  = dest_q;
  assign OutFlags = out_flags_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider (WIDTH=16); honours DIVIDER_ZERO_TRAP_EN.
module tb_iterative_divider;
  import iterative_divider_pkg::*;

`ifdef DIVIDER_ZERO_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        Start = 1'b0;
  eOperation   Operation = OP_ADD;
  logic [15:0] InDest = '0;
  logic [15:0] InSrc = '0;
  sFlags       InFlags = '0;
  logic        Busy, Done;
  logic [15:0] OutDest;
  sFlags       OutFlags;

  int errors = 0;
  int checks = 0;

  iterative_divider #(.WIDTH(16)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .Start     (Start),
    .Operation (Operation),
    .InDest    (InDest),
    .InSrc     (InSrc),
    .InFlags   (InFlags),
    .Busy      (Busy),
    .Done      (Done),
    .OutDest   (OutDest),
    .OutFlags  (OutFlags)
  );

  always #5 Clock = ~Clock;

  function automatic sFlags flg(logic c, logic z, logic n, logic o, logic p);
    sFlags f;
    f.Carry = c; f.Zero = z; f.Negative = n; f.Overflow = o; f.Parity = p;
    return f;
  endfunction

  function automatic logic ovf_exp(logic in_ovf, logic div0);
    return Trap ? div0 : in_ovf;
  endfunction

  // Drive a request for one cycle, then scramble operands to prove they are latched.
  task automatic issue(eOperation op, logic [15:0] a, logic [15:0] b, sFlags f);
    @(negedge Clock);
    Start = 1'b1; Operation = op; InDest = a; InSrc = b; InFlags = f;
    @(negedge Clock);
    Start = 1'b0; Operation = OP_MOD; InDest = 16'hDEAD; InSrc = 16'h0000; InFlags = '1;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge Clock);
      if (Done) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic do_op(eOperation op, logic [15:0] a, logic [15:0] b, sFlags f,
                       output int lat, output logic [15:0] d, output sFlags fl);
    issue(op, a, b, f);
    wait_done(lat);
    d  = OutDest;
    fl = OutFlags;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
    checks++; if (OutDest !== 16'h0000) begin errors++; $display("FAIL reset_dest got=%h exp=0000", OutDest); end
    checks++; if (OutFlags !== sFlags'('0)) begin errors++; $display("FAIL reset_flags got=%b exp=00000", OutFlags); end
  endtask

  task automatic test_div_basic();
    int lat;
    sFlags ef;
    issue(OP_DIV, 16'd100, 16'd7, flg(1, 0, 0, 1, 0));
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got=%b exp=1", Busy); end
    wait_done(lat);
    ef = flg(1, 0, 0, ovf_exp(1, 0), 0);
    checks++; if (lat !== 17) begin errors++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got=%b exp=0", Busy); end
    checks++; if (OutDest !== 16'd14) begin errors++; $display("FAIL basic_dest got=%h exp=000e", OutDest); end
    checks++; if (OutFlags !== ef) begin errors++; $display("FAIL basic_flags got=%b exp=%b", OutFlags, ef); end
    @(negedge Clock);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", Done); end
    checks++; if (OutDest !== 16'd14) begin errors++; $display("FAIL basic_dest_hold got=%h exp=000e", OutDest); end
  endtask

  task automatic test_signed();
    int lat; logic [15:0] d; sFlags fl, ef;
    do_op(OP_MOD, 16'hFF9C, 16'd7, '0, lat, d, fl);
    ef = flg(0, 0, 1, ovf_exp(0, 0), 0);
    checks++; if (d !== 16'hFFFE) begin errors++; $display("FAIL mod_neg_dest got=%h exp=fffe", d); end
    checks++; if (fl !== ef) begin errors++; $display("FAIL mod_neg_flags got=%b exp=%b", fl, ef); end
    do_op(OP_DIV, 16'hFF9C, 16'd7, '0, lat, d, fl);
    ef = flg(0, 0, 1, ovf_exp(0, 0), 0);
    checks++; if (d !== 16'hFFF2) begin errors++; $display("FAIL div_neg_dest got=%h exp=fff2", d); end
    checks++; if (fl !== ef) begin errors++; $display("FAIL div_neg_flags got=%b exp=%b", fl, ef); end
  endtask

  task automatic test_most_negative();
    int lat; logic [15:0] d; sFlags fl, ef;
    do_op(OP_DIV, 16'h8000, 16'hFFFF, '0, lat, d, fl);
    ef = flg(0, 0, 1, 0, 0);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL minneg_div_dest got=%h exp=8000", d); end
    checks++; if (fl !== ef) begin errors++; $display("FAIL minneg_div_flags got=%b exp=%b", fl, ef); end
    do_op(OP_MOD, 16'h8000, 16'hFFFF, '0, lat, d, fl);
    ef = flg(0, 1, 0, 0, 1);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL minneg_mod_dest got=%h exp=0000", d); end
    checks++; if (fl !== ef) begin errors++; $display("FAIL minneg_mod_flags got=%b exp=%b", fl, ef); end
  endtask

  task automatic test_zero_divisor();
    int lat; logic [15:0] d, ed; sFlags fl, ef;
    do_op(OP_DIV, 16'd5, 16'd0, flg(1, 0, 0, 0, 0), lat, d, fl);
    ed = Trap ? 16'h0005 : 16'hFFFF;
    ef = Trap ? flg(1, 0, 0, 1, 1) : flg(1, 0, 1, 0, 1);
    checks++; if (lat !== 17) begin errors++; $display("FAIL div0_latency got=%0d exp=17", lat); end
    checks++; if (d !== ed) begin errors++; $display("FAIL div0_pos_dest got=%h exp=%h", d, ed); end
    checks++; if (fl !== ef) begin errors++; $display("FAIL div0_pos_flags got=%b exp=%b", fl, ef); end
    do_op(OP_DIV, 16'hFFF9, 16'd0, flg(0, 0, 0, 1, 0), lat, d, fl);
    ed = Trap ? 16'hFFF9 : 16'h0001;
    ef = Trap ? flg(0, 0, 1, 1, 1) : flg(0, 0, 0, 1, 0);
    checks++; if (d !== ed) begin errors++; $display("FAIL div0_neg_dest got=%h exp=%h", d, ed); end
    checks++; if (fl !== ef) begin errors++; $display("FAIL div0_neg_flags got=%b exp=%b", fl, ef); end
    do_op(OP_MOD, 16'd5, 16'd0, '0, lat, d, fl);
    ef = flg(0, 0, 0, ovf_exp(0, 1), 1);
    checks++; if (d !== 16'h0005) begin errors++; $display("FAIL mod0_dest got=%h exp=0005", d); end
    checks++; if (fl !== ef) begin errors++; $display("FAIL mod0_flags got=%b exp=%b", fl, ef); end
  endtask

  task automatic test_back_to_back();
    int lat; sFlags ef;
    issue(OP_DIV, 16'd9, 16'd3, '0);
    repeat (4) @(negedge Clock);
    Start = 1'b1; Operation = OP_MOD; InDest = 16'd9; InSrc = 16'd4; InFlags = '0;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(lat);
    ef = flg(0, 0, 0, ovf_exp(0, 0), 1);
    checks++; if (lat !== 12) begin errors++; $display("FAIL busy_start_latency got=%0d exp=12", lat); end
    checks++; if (OutDest !== 16'd3) begin errors++; $display("FAIL busy_start_dest got=%h exp=0003", OutDest); end
    checks++; if (OutFlags !== ef) begin errors++; $display("FAIL busy_start_flags got=%b exp=%b", OutFlags, ef); end
    // Issue again during the Done cycle.
    Start = 1'b1; Operation = OP_MOD; InDest = 16'd9; InSrc = 16'd4; InFlags = flg(1, 0, 0, 0, 0);
    @(negedge Clock);
    Start = 1'b0; InDest = 16'hBEEF; InSrc = 16'h0001;
    checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", Busy, Done); end
    wait_done(lat);
    ef = flg(1, 0, 0, ovf_exp(0, 0), 0);
    checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_latency got=%0d exp=17", lat); end
    checks++; if (OutDest !== 16'd1) begin errors++; $display("FAIL b2b_dest got=%h exp=0001", OutDest); end
    checks++; if (OutFlags !== ef) begin errors++; $display("FAIL b2b_flags got=%b exp=%b", OutFlags, ef); end
  endtask

  task automatic test_midflight_reset();
    int seen_busy, seen_done;
    issue(OP_DIV, 16'd100, 16'd7, flg(1, 0, 0, 1, 0));
    repeat (7) @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got busy=%b done=%b exp 0 0", Busy, Done); end
    checks++; if (OutDest !== 16'h0000) begin errors++; $display("FAIL midreset_dest got=%h exp=0000", OutDest); end
    checks++; if (OutFlags !== sFlags'('0)) begin errors++; $display("FAIL midreset_flags got=%b exp=00000", OutFlags); end
    @(negedge Clock);
    nReset = 1'b1;
    issue(OP_ADD, 16'd100, 16'd7, '0);
    seen_busy = 0; seen_done = 0;
    repeat (20) begin
      if (Busy) seen_busy++;
      if (Done) seen_done++;
      @(negedge Clock);
    end
    checks++; if (seen_busy !== 0 || seen_done !== 0) begin errors++; $display("FAIL illegal_op got busy_cycles=%0d done_cycles=%0d exp 0 0", seen_busy, seen_done); end
  endtask

  initial begin
    test_reset();
    test_div_basic();
    test_signed();
    test_most_negative();
    test_zero_divisor();
    test_back_to_back();
    test_midflight_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
